// File: rtl/irq_controller.sv
// Edge-latched, masked, fixed-priority interrupt controller for the CPU IRQ line.
// Optional IRQ_TIMEOUT_EN: drop a request left unaccepted for TIMEOUT_CYC cycles.
module irq_controller #(
    parameter int NUM_SRC     = 4,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] src_irq,
    input  logic               pc_31,
    input  logic               bus_wr,
    input  logic [1:0]         bus_addr,
    input  logic [31:0]        bus_wdata,
    output logic [31:0]        bus_rdata,
    output logic               irq,
    output logic [2:0]         irq_id
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        REQ      = 3'd1,
        SERVICE  = 3'd2,
        WAIT_RET = 3'd3,
        RECOVER  = 3'd4
    } state_t;

    localparam logic [7:0] TO_LIM = 8'(TIMEOUT_CYC - 1);

    state_t             state_q;
    state_t             state_d;
    logic [NUM_SRC-1:0] pending_q;
    logic [NUM_SRC-1:0] pending_d;
    logic [NUM_SRC-1:0] mask_q;
    logic [NUM_SRC-1:0] mask_d;
    logic [NUM_SRC-1:0] src_prev;
    logic [NUM_SRC-1:0] src_edge;
    logic [NUM_SRC-1:0] pend_keep;
    logic [NUM_SRC-1:0] svc_clr;
    logic [NUM_SRC-1:0] cur_bit;
    logic [NUM_SRC-1:0] req_vec;
    logic               irq_d;
    logic [2:0]         irq_id_d;
    logic               win_ok;
    logic [2:0]         win_id;
    logic               in_service;
    logic               wr_pend;
    logic               wr_mask;
    logic               wr_act;
    logic               wr_stat;
    logic               to_expire;
    logic               to_hit;
    logic               timeout_flag;
    logic               unused_bits;

    assign wr_pend    = bus_wr && (bus_addr == 2'd0);
    assign wr_mask    = bus_wr && (bus_addr == 2'd1);
    assign wr_act     = bus_wr && (bus_addr == 2'd2);
    assign wr_stat    = bus_wr && (bus_addr == 2'd3);
    assign src_edge   = src_irq & ~src_prev;
    assign req_vec    = pending_q & mask_q;
    assign in_service = (state_q == SERVICE);
    assign unused_bits = &{1'b0, bus_wdata, to_hit, TO_LIM};

    always_comb begin
        win_ok = 1'b0;
        win_id = 3'd0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (req_vec[i]) begin
                win_ok = 1'b1;
                win_id = 3'(i);
            end
        end
    end

    always_comb begin
        cur_bit = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            cur_bit[i] = (irq_id == 3'(i));
        end
    end

    // Withdrawal looks at this cycle's bus write so irq drops with the write.
    always_comb begin
        state_d   = state_q;
        irq_d     = irq;
        irq_id_d  = irq_id;
        svc_clr   = '0;
        to_hit    = 1'b0;
        mask_d    = wr_mask ? bus_wdata[NUM_SRC-1:0] : mask_q;
        pend_keep = pending_q;
        if (wr_pend) begin
            pend_keep = pending_q & ~bus_wdata[NUM_SRC-1:0];
        end
        unique case (state_q)
            IDLE: begin
                if (win_ok && !pc_31) begin
                    state_d  = REQ;
                    irq_d    = 1'b1;
                    irq_id_d = win_id;
                end
            end
            REQ: begin
                if (pc_31) begin
                    state_d = SERVICE;
                    irq_d   = 1'b0;
                    svc_clr = cur_bit;
                end else if (~|(cur_bit & pend_keep & mask_d)) begin
                    state_d = IDLE;
                    irq_d   = 1'b0;
                end else if (to_expire) begin
                    state_d = IDLE;
                    irq_d   = 1'b0;
                    svc_clr = cur_bit;
                    to_hit  = 1'b1;
                end
            end
            SERVICE: begin
                if (!pc_31) begin
                    state_d = RECOVER;
                end else if (wr_act) begin
                    state_d = WAIT_RET;
                end
            end
            WAIT_RET: begin
                if (!pc_31) begin
                    state_d = RECOVER;
                end
            end
            RECOVER: begin
                state_d = IDLE;
                irq_d   = 1'b0;
            end
            default: begin
                state_d = IDLE;
                irq_d   = 1'b0;
            end
        endcase
        pending_d = (pend_keep & ~svc_clr) | src_edge;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            pending_q <= '0;
            mask_q    <= '0;
            src_prev  <= '0;
            irq       <= 1'b0;
            irq_id    <= 3'd0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            mask_q    <= mask_d;
            src_prev  <= src_irq;
            irq       <= irq_d;
            irq_id    <= irq_id_d;
        end
    end

`ifdef IRQ_TIMEOUT_EN
    logic [7:0] to_cnt;
    logic       to_flag_q;

    assign to_expire    = (state_q == REQ) && (to_cnt == TO_LIM);
    assign timeout_flag = to_flag_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            to_cnt    <= 8'd0;
            to_flag_q <= 1'b0;
        end else begin
            if (state_q == REQ && state_d == REQ) begin
                to_cnt <= to_cnt + 8'd1;
            end else begin
                to_cnt <= 8'd0;
            end
            if (to_hit) begin
                to_flag_q <= 1'b1;
            end else if (wr_stat && bus_wdata[0]) begin
                to_flag_q <= 1'b0;
            end
        end
    end
`else
    assign to_expire    = 1'b0;
    assign timeout_flag = 1'b0 & wr_stat;
`endif

    always_comb begin
        bus_rdata = '0;
        unique case (bus_addr)
            2'd0: bus_rdata[NUM_SRC-1:0] = pending_q;
            2'd1: bus_rdata[NUM_SRC-1:0] = mask_q;
            2'd2: bus_rdata[3:0] = {in_service, irq_id};
            2'd3: bus_rdata[2:0] = {state_q[1:0], timeout_flag};
            default: bus_rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller: priority, masking, service/return flow.
module tb_irq_controller;

`ifdef IRQ_TIMEOUT_EN
    localparam int TO_CYC = 4;
`else
    localparam int TO_CYC = 255;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  src_irq;
    logic        pc_31;
    logic        bus_wr;
    logic [1:0]  bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        irq;
    logic [2:0]  irq_id;

    int checks = 0;
    int errors = 0;

    irq_controller #(
        .NUM_SRC(4),
        .TIMEOUT_CYC(TO_CYC)
    ) dut (
        .clk(clk),
        .reset(reset),
        .src_irq(src_irq),
        .pc_31(pc_31),
        .bus_wr(bus_wr),
        .bus_addr(bus_addr),
        .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata),
        .irq(irq),
        .irq_id(irq_id)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        bus_wr = 1'b1;
        bus_addr = a;
        bus_wdata = d;
        tick();
        bus_wr = 1'b0;
        bus_wdata = '0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        bus_addr = a;
        #1;
        d = bus_rdata;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        src_irq = '0;
        pc_31 = 1'b0;
        bus_wr = 1'b0;
        bus_addr = '0;
        bus_wdata = '0;
        tick(2);
        reset = 1'b0;
    endtask

    task automatic pulse(input logic [3:0] s);
        src_irq = s;
        tick();
        src_irq = '0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        do_reset();
        checks++;
        if (irq !== 1'b0 || irq_id !== 3'd0) begin
            errors++;
            $display("FAIL reset_out irq=%b id=%0d exp 0/0", irq, irq_id);
        end
        for (int a = 0; a < 4; a++) begin
            rd(2'(a), d);
            checks++;
            if (d !== 32'h0) begin
                errors++;
                $display("FAIL reset_reg%0d got=%h exp=0", a, d);
            end
        end
    endtask

    task automatic test_basic();
        logic [31:0] d;
        do_reset();
        bus_write(2'd1, 32'h5);
        pulse(4'b0100);
        rd(2'd0, d);
        checks++;
        if (d !== 32'h4 || irq !== 1'b0) begin
            errors++;
            $display("FAIL basic_pend pend=%h irq=%b exp 4/0", d, irq);
        end
        tick();
        checks++;
        if (irq !== 1'b1 || irq_id !== 3'd2) begin
            errors++;
            $display("FAIL basic_req irq=%b id=%0d exp 1/2", irq, irq_id);
        end
        pc_31 = 1'b1;
        tick();
        rd(2'd0, d);
        checks++;
        if (irq !== 1'b0 || d !== 32'h0) begin
            errors++;
            $display("FAIL basic_acc irq=%b pend=%h exp 0/0", irq, d);
        end
        rd(2'd2, d);
        checks++;
        if (d !== 32'hA) begin
            errors++;
            $display("FAIL basic_active got=%h exp=a", d);
        end
        rd(2'd3, d);
        checks++;
        if (d !== 32'h4) begin
            errors++;
            $display("FAIL basic_svc_state got=%h exp=4", d);
        end
        bus_write(2'd2, 32'h0);
        rd(2'd2, d);
        checks++;
        if (d !== 32'h2) begin
            errors++;
            $display("FAIL basic_eoi active=%h exp=2", d);
        end
        rd(2'd3, d);
        checks++;
        if (d !== 32'h6) begin
            errors++;
            $display("FAIL basic_waitret got=%h exp=6", d);
        end
        pc_31 = 1'b0;
        tick(2);
        rd(2'd3, d);
        checks++;
        if (d !== 32'h0 || irq !== 1'b0) begin
            errors++;
            $display("FAIL basic_idle st=%h irq=%b exp 0/0", d, irq);
        end
    endtask

    task automatic test_priority();
        logic [31:0] d;
        do_reset();
        bus_write(2'd1, 32'hF);
        pulse(4'b1001);
        tick();
        checks++;
        if (irq !== 1'b1 || irq_id !== 3'd0) begin
            errors++;
            $display("FAIL prio_first irq=%b id=%0d exp 1/0", irq, irq_id);
        end
        pc_31 = 1'b1;
        tick();
        bus_write(2'd2, 32'h0);
        pc_31 = 1'b0;
        tick();
        rd(2'd3, d);
        checks++;
        if (irq !== 1'b0 || d !== 32'h0) begin
            errors++;
            $display("FAIL prio_recover irq=%b st=%h exp 0/0", irq, d);
        end
        tick();
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL prio_idle irq=%b exp=0", irq);
        end
        tick();
        checks++;
        if (irq !== 1'b1 || irq_id !== 3'd3) begin
            errors++;
            $display("FAIL prio_second irq=%b id=%0d exp 1/3", irq, irq_id);
        end
    endtask

    task automatic test_mask();
        logic [31:0] d;
        do_reset();
        pulse(4'b0010);
        tick();
        rd(2'd0, d);
        checks++;
        if (d !== 32'h2 || irq !== 1'b0) begin
            errors++;
            $display("FAIL mask_off pend=%h irq=%b exp 2/0", d, irq);
        end
        bus_write(2'd1, 32'h2);
        tick();
        checks++;
        if (irq !== 1'b1 || irq_id !== 3'd1) begin
            errors++;
            $display("FAIL mask_on irq=%b id=%0d exp 1/1", irq, irq_id);
        end
        bus_write(2'd0, 32'h2);
        rd(2'd3, d);
        checks++;
        if (irq !== 1'b0 || d !== 32'h0) begin
            errors++;
            $display("FAIL mask_w1c irq=%b st=%h exp 0/0", irq, d);
        end
        src_irq = 4'b0100;
        bus_wr = 1'b1;
        bus_addr = 2'd0;
        bus_wdata = 32'h4;
        tick();
        bus_wr = 1'b0;
        src_irq = '0;
        rd(2'd0, d);
        checks++;
        if (d !== 32'h4) begin
            errors++;
            $display("FAIL set_wins pend=%h exp=4", d);
        end
        bus_write(2'd2, 32'h0);
        rd(2'd3, d);
        checks++;
        if (d !== 32'h0) begin
            errors++;
            $display("FAIL eoi_idle st=%h exp=0", d);
        end
    endtask

    task automatic test_reentry();
        logic [31:0] d;
        do_reset();
        bus_write(2'd1, 32'h2);
        pulse(4'b0010);
        tick();
        pc_31 = 1'b1;
        tick();
        pulse(4'b0010);
        rd(2'd0, d);
        checks++;
        if (d !== 32'h2) begin
            errors++;
            $display("FAIL reent_pend pend=%h exp=2", d);
        end
        pc_31 = 1'b0;
        tick();
        rd(2'd3, d);
        checks++;
        if (d !== 32'h0 || irq !== 1'b0) begin
            errors++;
            $display("FAIL reent_recover st=%h irq=%b exp 0/0", d, irq);
        end
        tick(2);
        checks++;
        if (irq !== 1'b1 || irq_id !== 3'd1) begin
            errors++;
            $display("FAIL reent_req irq=%b id=%0d exp 1/1", irq, irq_id);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        do_reset();
        bus_write(2'd1, 32'h8);
        pulse(4'b1001);
        tick();
        pc_31 = 1'b1;
        tick();
        rd(2'd2, d);
        checks++;
        if (d !== 32'hB) begin
            errors++;
            $display("FAIL mid_active got=%h exp=b", d);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (irq !== 1'b0 || irq_id !== 3'd0) begin
            errors++;
            $display("FAIL mid_out irq=%b id=%0d exp 0/0", irq, irq_id);
        end
        for (int a = 0; a < 4; a++) begin
            rd(2'(a), d);
            checks++;
            if (d !== 32'h0) begin
                errors++;
                $display("FAIL mid_reg%0d got=%h exp=0", a, d);
            end
        end
        pc_31 = 1'b0;
    endtask

    task automatic test_noaccept();
        logic [31:0] d;
        int bad;
        do_reset();
        bus_write(2'd1, 32'h1);
        pulse(4'b0001);
        tick();
        bad = 0;
`ifdef IRQ_TIMEOUT_EN
        for (int i = 0; i < 3; i++) begin
            if (irq !== 1'b1) bad++;
            tick();
        end
        checks++;
        if (bad != 0 || irq !== 1'b1) begin
            errors++;
            $display("FAIL to_hold bad=%0d irq=%b exp 0/1", bad, irq);
        end
        tick();
        rd(2'd3, d);
        checks++;
        if (irq !== 1'b0 || d !== 32'h1) begin
            errors++;
            $display("FAIL to_drop irq=%b st=%h exp 0/1", irq, d);
        end
        rd(2'd0, d);
        checks++;
        if (d !== 32'h0) begin
            errors++;
            $display("FAIL to_pend pend=%h exp=0", d);
        end
        bus_write(2'd3, 32'h1);
        rd(2'd3, d);
        checks++;
        if (d !== 32'h0) begin
            errors++;
            $display("FAIL to_clear st=%h exp=0", d);
        end
`else
        for (int i = 0; i < 100; i++) begin
            if (irq !== 1'b1) bad++;
            tick();
        end
        rd(2'd3, d);
        checks++;
        if (bad != 0 || d !== 32'h2) begin
            errors++;
            $display("FAIL hold100 bad=%0d st=%h exp 0/2", bad, d);
        end
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_priority();
        test_mask();
        test_reentry();
        test_reset_mid();
        test_noaccept();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
